bus_arbiter: RTL and testbench

Three-master arbiter for the shared 16-bit-address / 8-bit-data system bus, sitting between the VGA fetcher, the UART debug master, the Z80 CPU and the external memory bus. It replaces the ad-hoc priority muxing at the computer top level. It grants the bus to one master per transaction using fixed priority (VGA > UART > CPU), with a CPU anti-starvation override. It registers the granted master's request onto the bus, returns a one-cycle ack with latched read data, and aborts transactions the slave never acknowledges.

---
 rtl/bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Three-master bus arbiter: fixed priority VGA > UART > CPU with a CPU
// anti-starvation override, registered bus request, one-cycle ack and slave timeout.
module bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_vga_cs,
  input  logic [15:0] i_vga_addr,
  output logic        o_vga_ack,
  input  logic        i_uart_cs,
  input  logic        i_uart_we,
  input  logic [15:0] i_uart_addr,
  input  logic [7:0]  i_uart_dat,
  output logic        o_uart_ack,
  input  logic        i_cpu_cs,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_dat,
  output logic        o_cpu_ack,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dat,
  output logic        o_we,
  output logic        o_cs,
  input  logic        i_ack,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_rdat,
  output logic [2:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] STARVE_MAX   = 8'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  ack_q, ack_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic        tout_q, tout_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  rdat_q, rdat_d;
  logic [7:0]  starve_q, starve_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        cpu_boost_s;
  logic [2:0]  win_s;

  // Winner selection, one-hot {cpu,uart,vga}; a starved CPU overrides priority.
  always_comb begin
    cpu_boost_s = i_cpu_cs && (starve_q == STARVE_MAX);
    win_s       = 3'b000;
    if (cpu_boost_s) begin
      win_s = 3'b100;
    end else if (i_vga_cs) begin
      win_s = 3'b001;
    end else if (i_uart_cs) begin
      win_s = 3'b010;
    end else if (i_cpu_cs) begin
      win_s = 3'b100;
    end else begin
      win_s = 3'b000;
    end
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = ack_q;
    cs_d     = cs_q;
    we_d     = we_q;
    tout_d   = tout_q;
    addr_d   = addr_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    starve_d = starve_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_s != 3'b000) begin
          state_d = ST_BUS;
          grant_d = win_s;
          cs_d    = 1'b1;
          tcnt_d  = 8'd0;
          case (win_s)
            3'b001: begin
              addr_d = i_vga_addr;
              dat_d  = 8'd0;
              we_d   = 1'b0;
            end
            3'b010: begin
              addr_d = i_uart_addr;
              dat_d  = i_uart_dat;
              we_d   = i_uart_we;
            end
            default: begin
              addr_d = i_cpu_addr;
              dat_d  = i_cpu_dat;
              we_d   = i_cpu_we;
            end
          endcase
          // Count only arbitrations the waiting CPU loses, saturating at the limit.
          if (win_s[2]) begin
            starve_d = 8'd0;
          end else if (i_cpu_cs && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 8'd1;
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (i_ack || (tcnt_q == TIMEOUT_LAST)) begin
          state_d = ST_DONE;
          cs_d    = 1'b0;
          we_d    = 1'b0;
          addr_d  = 16'd0;
          dat_d   = 8'd0;
          ack_d   = grant_q;
          if (i_ack) begin
            rdat_d = i_dat;
          end else begin
            rdat_d = 8'hFF;
            tout_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ack_d   = 3'b000;
        tout_d  = 1'b0;
        grant_d = 3'b000;
        tcnt_d  = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
        ack_d   = 3'b000;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        tout_d  = 1'b0;
        addr_d  = 16'd0;
        dat_d   = 8'd0;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  // State and output registers; async reset drops the bus request immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 3'b000;
      ack_q    <= 3'b000;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      tout_q   <= 1'b0;
      addr_q   <= 16'd0;
      dat_q    <= 8'd0;
      rdat_q   <= 8'd0;
      starve_q <= 8'd0;
      tcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      tout_q   <= tout_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      rdat_q   <= rdat_d;
      starve_q <= starve_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign o_vga_ack  = ack_q[0];
  assign o_uart_ack = ack_q[1];
  assign o_cpu_ack  = ack_q[2];
  assign o_addr     = addr_q;
  assign o_dat      = dat_q;
  assign o_we       = we_q;
  assign o_cs       = cs_q;
  assign o_rdat     = rdat_q;
  assign o_grant    = grant_q;
  assign o_timeout  = tout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (STARVE_LIMIT=2, TIMEOUT=4); outputs are
// checked on the falling edge, inputs are changed there too.
module tb_bus_arbiter;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_vga_cs;
  logic [15:0] i_vga_addr;
  logic        o_vga_ack;
  logic        i_uart_cs;
  logic        i_uart_we;
  logic [15:0] i_uart_addr;
  logic [7:0]  i_uart_dat;
  logic        o_uart_ack;
  logic        i_cpu_cs;
  logic        i_cpu_we;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_dat;
  logic        o_cpu_ack;
  logic [15:0] o_addr;
  logic [7:0]  o_dat;
  logic        o_we;
  logic        o_cs;
  logic        i_ack;
  logic [7:0]  i_dat;
  logic [7:0]  o_rdat;
  logic [2:0]  o_grant;
  logic        o_timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] starve_exp [0:3];

  bus_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_vga_cs(i_vga_cs), .i_vga_addr(i_vga_addr), .o_vga_ack(o_vga_ack),
    .i_uart_cs(i_uart_cs), .i_uart_we(i_uart_we), .i_uart_addr(i_uart_addr),
    .i_uart_dat(i_uart_dat), .o_uart_ack(o_uart_ack),
    .i_cpu_cs(i_cpu_cs), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_dat(i_cpu_dat), .o_cpu_ack(o_cpu_ack),
    .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs),
    .i_ack(i_ack), .i_dat(i_dat), .o_rdat(o_rdat), .o_grant(o_grant),
    .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_vga_cs    = 1'b0;
    i_vga_addr  = 16'd0;
    i_uart_cs   = 1'b0;
    i_uart_we   = 1'b0;
    i_uart_addr = 16'd0;
    i_uart_dat  = 8'd0;
    i_cpu_cs    = 1'b0;
    i_cpu_we    = 1'b0;
    i_cpu_addr  = 16'd0;
    i_cpu_dat   = 8'd0;
    i_ack       = 1'b0;
    i_dat       = 8'd0;
    starve_exp[0] = 3'b001;
    starve_exp[1] = 3'b001;
    starve_exp[2] = 3'b100;
    starve_exp[3] = 3'b001;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk1("rst_cs", o_cs, 1'b0);
    chk3("rst_grant", o_grant, 3'b000);
    chk3("rst_acks", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b000);
    chk16("rst_addr", o_addr, 16'h0000);
    chk8("rst_rdat", o_rdat, 8'h00);
    chk1("rst_timeout", o_timeout, 1'b0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    chk1("idle_cs", o_cs, 1'b0);

    // CPU write, slave acks in the second BUS cycle
    i_cpu_cs = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 16'h1234; i_cpu_dat = 8'hA5; i_dat = 8'h77;
    @(negedge i_clk);
    chk1("wr_cs_c1", o_cs, 1'b1);
    chk16("wr_addr_c1", o_addr, 16'h1234);
    chk8("wr_dat_c1", o_dat, 8'hA5);
    chk1("wr_we_c1", o_we, 1'b1);
    chk3("wr_grant_c1", o_grant, 3'b100);
    chk1("wr_ack_early", o_cpu_ack, 1'b0);
    @(negedge i_clk);
    chk1("wr_cs_c2", o_cs, 1'b1);
    chk16("wr_addr_c2", o_addr, 16'h1234);
    chk1("wr_ack_c2", o_cpu_ack, 1'b0);
    i_ack = 1'b1;
    @(negedge i_clk);
    chk1("wr_done_cs", o_cs, 1'b0);
    chk1("wr_done_ack", o_cpu_ack, 1'b1);
    chk3("wr_done_grant", o_grant, 3'b100);
    chk1("wr_done_we", o_we, 1'b0);
    chk16("wr_done_addr", o_addr, 16'h0000);
    chk8("wr_done_rdat", o_rdat, 8'h77);
    i_ack = 1'b0; i_cpu_cs = 1'b0; i_cpu_we = 1'b0;
    @(negedge i_clk);
    chk1("wr_ack_once", o_cpu_ack, 1'b0);
    chk3("wr_idle_grant", o_grant, 3'b000);

    // Simultaneous requests, slave acks immediately
    i_vga_cs = 1'b1; i_vga_addr = 16'h0100;
    i_uart_cs = 1'b1; i_uart_we = 1'b0; i_uart_addr = 16'h0200; i_uart_dat = 8'h55;
    i_cpu_cs = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 16'h0300; i_cpu_dat = 8'h3C;
    i_ack = 1'b1; i_dat = 8'h11;
    @(negedge i_clk);
    chk3("sim_grant_vga", o_grant, 3'b001);
    chk16("sim_addr_vga", o_addr, 16'h0100);
    chk1("sim_we_vga", o_we, 1'b0);
    chk8("sim_dat_vga", o_dat, 8'h00);
    @(negedge i_clk);
    chk3("sim_ack_vga", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b001);
    i_vga_cs = 1'b0;
    @(negedge i_clk);
    chk3("sim_acks_off1", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b000);
    @(negedge i_clk);
    chk3("sim_grant_uart", o_grant, 3'b010);
    chk16("sim_addr_uart", o_addr, 16'h0200);
    @(negedge i_clk);
    chk3("sim_ack_uart", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b010);
    i_uart_cs = 1'b0;
    @(negedge i_clk);
    chk3("sim_acks_off2", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b000);
    @(negedge i_clk);
    chk3("sim_grant_cpu", o_grant, 3'b100);
    chk16("sim_addr_cpu", o_addr, 16'h0300);
    chk8("sim_dat_cpu", o_dat, 8'h3C);
    @(negedge i_clk);
    chk3("sim_ack_cpu", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b100);
    i_cpu_cs = 1'b0;
    @(negedge i_clk);
    chk3("sim_acks_off3", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b000);

    // Starvation: all three keep requesting, CPU must win the third arbitration
    i_vga_cs = 1'b1; i_uart_cs = 1'b1; i_cpu_cs = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk3($sformatf("starve_grant_%0d", k), o_grant, starve_exp[k]);
      if (k == 3) begin
        i_vga_cs = 1'b0; i_uart_cs = 1'b0; i_cpu_cs = 1'b0;
      end
      @(negedge i_clk);
      chk3($sformatf("starve_ack_%0d", k), {o_cpu_ack, o_uart_ack, o_vga_ack}, starve_exp[k]);
      @(negedge i_clk);
    end
    i_ack = 1'b0;

    // Timeout: UART read never acknowledged
    i_uart_cs = 1'b1; i_uart_we = 1'b0; i_uart_addr = 16'h0ABC;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk1($sformatf("to_cs_%0d", k), o_cs, 1'b1);
      chk1($sformatf("to_ack_early_%0d", k), o_uart_ack, 1'b0);
    end
    @(negedge i_clk);
    chk1("to_done_cs", o_cs, 1'b0);
    chk1("to_done_ack", o_uart_ack, 1'b1);
    chk8("to_done_rdat", o_rdat, 8'hFF);
    chk1("to_done_flag", o_timeout, 1'b1);
    chk3("to_done_grant", o_grant, 3'b010);
    i_uart_cs = 1'b0;
    @(negedge i_clk);
    chk1("to_flag_once", o_timeout, 1'b0);
    chk1("to_ack_once", o_uart_ack, 1'b0);
    chk8("to_rdat_hold", o_rdat, 8'hFF);

    // CPU read with cs dropped mid-BUS
    i_cpu_cs = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h4321;
    @(negedge i_clk);
    chk3("rd_grant", o_grant, 3'b100);
    chk1("rd_we", o_we, 1'b0);
    i_cpu_cs = 1'b0;
    @(negedge i_clk);
    chk1("rd_cs_after_drop", o_cs, 1'b1);
    chk16("rd_addr_after_drop", o_addr, 16'h4321);
    i_ack = 1'b1; i_dat = 8'h5C;
    @(negedge i_clk);
    chk1("rd_ack", o_cpu_ack, 1'b1);
    chk8("rd_rdat", o_rdat, 8'h5C);
    i_ack = 1'b0; i_dat = 8'h00;
    @(negedge i_clk);
    chk1("rd_ack_once", o_cpu_ack, 1'b0);
    chk8("rd_rdat_hold1", o_rdat, 8'h5C);
    @(negedge i_clk);
    chk8("rd_rdat_hold2", o_rdat, 8'h5C);

    // Asynchronous reset in the middle of a BUS cycle
    i_vga_cs = 1'b1; i_vga_addr = 16'h0F0F;
    @(negedge i_clk);
    chk1("rb_cs", o_cs, 1'b1);
    chk3("rb_grant", o_grant, 3'b001);
    #2 i_reset_n = 1'b0;
    #1;
    chk1("rb_cs_async", o_cs, 1'b0);
    chk3("rb_grant_async", o_grant, 3'b000);
    chk3("rb_acks_async", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b000);
    i_vga_cs = 1'b0;
    repeat (2) @(negedge i_clk);
    chk1("rb_timeout_held", o_timeout, 1'b0);
    chk3("rb_acks_held", {o_cpu_ack, o_uart_ack, o_vga_ack}, 3'b000);
    chk8("rb_rdat_cleared", o_rdat, 8'h00);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    i_vga_cs = 1'b1; i_vga_addr = 16'h0AAA; i_ack = 1'b1; i_dat = 8'hC3;
    @(negedge i_clk);
    chk3("post_grant", o_grant, 3'b001);
    chk1("post_cs", o_cs, 1'b1);
    chk16("post_addr", o_addr, 16'h0AAA);
    @(negedge i_clk);
    chk1("post_ack", o_vga_ack, 1'b1);
    chk8("post_rdat", o_rdat, 8'hC3);
    i_vga_cs = 1'b0; i_ack = 1'b0;
    @(negedge i_clk);
    chk1("post_ack_once", o_vga_ack, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
